// File: rtl/upsample_scheduler_if.sv
// Pixel-FIFO read port and downstream valid/ready stream of the 2x upsampler.
// The scheduler drives the master side; the FIFO and the blur stage sit on the slave side.
interface upsample_scheduler_if #(
  parameter int DATA_W = 8
);
  logic              empty;
  logic              rd_en;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              valid_out;
  logic              ready_out;

  modport master (
    input  empty, din, ready_out,
    output rd_en, dout, valid_out
  );

  modport slave (
    output empty, din, ready_out,
    input  rd_en, dout, valid_out
  );
endinterface

// File: rtl/upsample_scheduler.sv
// 2x nearest-neighbour upsampler: buffers one source row, then streams it twice
// with every pixel repeated, one row at a time, until the whole frame is sent.
module upsample_scheduler #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  upsample_scheduler_if.master bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, FILL, EMIT, DRAIN} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_issued;
  logic              r_issue_done;
  logic              r_rd_en_q;
  logic [CW-1:0]     r_wr_col;
  logic [CW-1:0]     r_col;
  logic              r_h;
  logic              r_v;
  logic [RW-1:0]     r_row;
  logic [DATA_W-1:0] r_linebuf [IMG_W];
  logic [DATA_W-1:0] r_dout;
  logic              r_valid;
  logic              r_frame_done;

  logic w_rd_en;
  logic w_xfer;
  logic w_load;
  logic w_row_end;
  logic w_fill_done;

  assign w_rd_en     = (r_state == FILL) && !bus.empty && !r_issue_done;
  assign w_xfer      = r_valid && bus.ready_out;
  assign w_load      = (r_state == EMIT) && (!r_valid || bus.ready_out);
  assign w_row_end   = r_h && r_v && (r_col == LAST_COL);
  assign w_fill_done = r_rd_en_q && (r_wr_col == LAST_COL);

  // NOTE: state lives in always_ff with non-blocking (<=) assignments so every
  // register samples the pre-edge values of the others, whatever the block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case; a path that leaves it
  // unassigned would infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (start) w_next = FILL;
      FILL:  if (w_fill_done) w_next = EMIT;
      EMIT:  if (w_load && w_row_end) w_next = (r_row == LAST_ROW) ? DRAIN : FILL;
      DRAIN: if (w_xfer) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Read side: count issued strobes, then place returning data one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issued     <= '0;
      r_issue_done <= 1'b0;
      r_rd_en_q    <= 1'b0;
      r_wr_col     <= '0;
    end else begin
      r_rd_en_q <= w_rd_en;
      if (r_state != FILL) begin
        r_issued     <= '0;
        r_issue_done <= 1'b0;
      end else if (w_rd_en) begin
        if (r_issued == LAST_COL) r_issue_done <= 1'b1;
        else                      r_issued     <= r_issued + 1'b1;
      end
      if (r_rd_en_q) r_wr_col <= (r_wr_col == LAST_COL) ? '0 : r_wr_col + 1'b1;
    end
  end

  // NOTE: the line buffer has no reset; every entry is rewritten before it is
  // read, so clearing it would only cost a reset fan-out to plain storage.
  always_ff @(posedge clk) begin
    if (r_rd_en_q) r_linebuf[r_wr_col] <= bus.din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col        <= '0;
      r_h          <= 1'b0;
      r_v          <= 1'b0;
      r_row        <= '0;
      r_dout       <= '0;
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == DRAIN) && w_xfer;
      if (r_state == IDLE) r_row <= '0;
      if (w_load) begin
        r_dout  <= r_linebuf[r_col];
        r_valid <= 1'b1;
        r_h     <= ~r_h;
        if (r_h) begin
          r_col <= (r_col == LAST_COL) ? '0 : r_col + 1'b1;
          if (r_col == LAST_COL) begin
            r_v <= ~r_v;
            if (r_v && (r_row != LAST_ROW)) r_row <= r_row + 1'b1;
          end
        end
      end else begin
        // The last beat of a row may still be waiting while the buffer refills.
        if (w_xfer) r_valid <= 1'b0;
        if (r_state != EMIT) begin
          r_col <= '0;
          r_h   <= 1'b0;
          r_v   <= 1'b0;
        end
      end
    end
  end

  assign busy          = (r_state != IDLE);
  assign frame_done    = r_frame_done;
  assign bus.rd_en     = w_rd_en;
  assign bus.dout      = r_dout;
  assign bus.valid_out = r_valid;

endmodule

// File: tb/tb_upsample_scheduler.sv
// Self-checking bench for upsample_scheduler: FIFO and sink models, a table of
// frame scenarios, and hand-written reset and backpressure sequences.
module tb_upsample_scheduler;

  localparam int DW    = 8;
  localparam int W     = 4;
  localparam int H     = 2;
  localparam int NPIX  = W * H;
  localparam int NBEAT = 4 * W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic frame_done;

  upsample_scheduler_if #(.DATA_W(DW)) bus ();

  upsample_scheduler #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus controls, written only by the main sequence.
  bit          starve_mode = 1'b0;
  bit          rnd_empty   = 1'b0;
  bit          rnd_ready   = 1'b0;
  int          bp_from     = -100;
  int          bp_to       = -100;
  int          flush_to    = 0;
  logic [7:0]  src[$];
  logic [7:0]  frame_pix[$];
  int          start_cyc   = 0;

  // Source FIFO model: data appears on din in the cycle after the strobe.
  int         rd_ptr   = 0;
  int         rd_count = 0;
  int         rd_viol  = 0;
  bit         tog      = 1'b0;
  logic [7:0] stage    = '0;
  initial begin
    bus.empty = 1'b1;
    bus.din   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_ptr < flush_to) rd_ptr = flush_to;
      tog = ~tog;
      bus.empty = (rd_ptr >= src.size()) || (starve_mode && tog) ||
                  (rnd_empty && ($urandom_range(0, 2) == 0));
      @(negedge clk);
      bus.din = stage;
      if (bus.rd_en) begin
        rd_count++;
        if (bus.empty || (rd_ptr >= src.size())) rd_viol++;
        else begin
          stage = src[rd_ptr];
          rd_ptr++;
        end
      end
    end
  end

  // Downstream sink: ready is high except inside a backpressure window or at random.
  initial begin
    bus.ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.ready_out = !((cyc >= bp_from) && (cyc < bp_to)) &&
                      (!rnd_ready || ($urandom_range(0, 3) != 0));
    end
  end

  // Monitor: record every transfer and every frame_done pulse.
  logic [7:0] got[$];
  int         got_cyc[$];
  int         done_cyc[$];
  bit         done_busy[$];
  always @(negedge clk) begin
    if (bus.valid_out && bus.ready_out) begin
      got.push_back(bus.dout);
      got_cyc.push_back(cyc);
    end
    if (frame_done) begin
      done_cyc.push_back(cyc);
      done_busy.push_back(busy);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    bit starve;
    bit r_ready;
    bit r_empty;
    bit r_pix;
    int base;
    int bp_rel;
    int mid_rel;
    bit chk_timing;
    int exp_beats;
    int exp_frames;
    int exp_reads;
  } vec_t;

  vec_t  vecs[7];
  string names[7];

  task automatic load_frame(input bit rnd, input int base);
    logic [7:0] p;
    frame_pix.delete();
    for (int i = 0; i < NPIX; i++) begin
      p = rnd ? 8'($urandom_range(0, 255)) : 8'(base + i);
      frame_pix.push_back(p);
      src.push_back(p);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int gbase, dbase, rbase, vbase, n;
    logic [7:0] exp_q[$];
    starve_mode = v.starve;
    rnd_ready   = v.r_ready;
    rnd_empty   = v.r_empty;
    load_frame(v.r_pix, v.base);
    gbase = got.size();
    dbase = done_cyc.size();
    rbase = rd_count;
    vbase = rd_viol;
    pulse_start();

    if (v.bp_rel >= 0) begin
      bp_from = start_cyc + v.bp_rel;
      bp_to   = bp_from + 3;
      while (cyc < bp_from) begin
        @(posedge clk);
        #1;
      end
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check($sformatf("%s hold valid c%0d", name, k), 32'(bus.valid_out), 1);
        check($sformatf("%s hold dout c%0d", name, k), 32'(bus.dout), 2);
      end
    end

    if (v.mid_rel >= 0) begin
      while (cyc < start_cyc + v.mid_rel) begin
        @(posedge clk);
        #1;
      end
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end

    n = 0;
    while ((done_cyc.size() <= dbase) && (n < 2000)) begin
      @(posedge clk);
      n++;
    end
    check({name, " frame_done seen"}, 32'(done_cyc.size() > dbase), 1);
    repeat (20) @(posedge clk);

    for (int r = 0; r < H; r++)
      for (int rep = 0; rep < 2; rep++)
        for (int c = 0; c < W; c++) begin
          exp_q.push_back(frame_pix[r * W + c]);
          exp_q.push_back(frame_pix[r * W + c]);
        end

    check({name, " beat count"}, 32'(got.size() - gbase), 32'(v.exp_beats));
    for (int i = 0; i < NBEAT; i++)
      if (gbase + i < got.size())
        check($sformatf("%s beat %0d", name, i), 32'(got[gbase + i]), 32'(exp_q[i]));
    check({name, " frame_done count"}, 32'(done_cyc.size() - dbase), 32'(v.exp_frames));
    if (done_cyc.size() > dbase)
      check({name, " busy at frame_done"}, 32'(done_busy[dbase]), 0);
    check({name, " read count"}, 32'(rd_count - rbase), 32'(v.exp_reads));
    check({name, " read while empty"}, 32'(rd_viol - vbase), 0);

    if (v.chk_timing && (got.size() >= gbase + NBEAT) && (done_cyc.size() > dbase)) begin
      check({name, " first beat cycle"}, 32'(got_cyc[gbase] - start_cyc), 32'(W + 3));
      check({name, " row1 first beat cycle"}, 32'(got_cyc[gbase + 4 * W] - start_cyc),
            32'(W + 3 + 5 * W + 1));
      check({name, " last beat cycle"}, 32'(got_cyc[gbase + NBEAT - 1] - start_cyc),
            32'(H * (5 * W + 1) + 1));
      check({name, " frame_done cycle"}, 32'(done_cyc[dbase] - start_cyc),
            32'(H * (5 * W + 1) + 2));
    end

    bp_from     = -100;
    bp_to       = -100;
    starve_mode = 1'b0;
    rnd_ready   = 1'b0;
    rnd_empty   = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_seen;
    bit found;
    int n;

    //          starve rrdy remp rpix base bp  mid  tim beats  frames reads
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  -1, -1, 1'b1, NBEAT, 1, NPIX}; names[0] = "nominal";
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  -1, -1, 1'b0, NBEAT, 1, NPIX}; names[1] = "starve";
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1,   9, -1, 1'b0, NBEAT, 1, NPIX}; names[2] = "backpressure";
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  -1, 12, 1'b0, NBEAT, 1, NPIX}; names[3] = "start_busy";
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 0,  -1, -1, 1'b0, NBEAT, 1, NPIX}; names[4] = "random_a";
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 0,  -1, -1, 1'b0, NBEAT, 1, NPIX}; names[5] = "random_b";
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 9,  -1, -1, 1'b1, NBEAT, 1, NPIX}; names[6] = "after_reset";

    // Reset: FIFO holds data but no start is given.
    load_frame(1'b0, 100);
    repeat (3) @(posedge clk);
    #1;
    check("reset dout", 32'(bus.dout), 0);
    check("reset valid_out", 32'(bus.valid_out), 0);
    rst = 1'b0;
    rd_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rd_en) rd_seen++;
    end
    check("idle rd_en pulses", 32'(rd_seen), 0);
    check("idle busy", 32'(busy), 0);
    check("idle frame_done", 32'(frame_done), 0);
    check("idle valid_out", 32'(bus.valid_out), 0);
    check("idle dout", 32'(bus.dout), 0);
    flush_to = src.size();

    for (int t = 0; t < 6; t++) run_vec(names[t], vecs[t]);

    // Reset in the middle of EMIT, then a clean frame.
    load_frame(1'b0, 1);
    pulse_start();
    found = 1'b0;
    n = 0;
    while (!found && (n < 200)) begin
      @(negedge clk);
      n++;
      if (bus.valid_out && (bus.dout == 8'd3)) found = 1'b1;
    end
    check("mid reset reached dout=3", 32'(found), 1);
    #1;
    rst = 1'b1;
    #1;
    check("mid reset dout", 32'(bus.dout), 0);
    check("mid reset valid_out", 32'(bus.valid_out), 0);
    check("mid reset busy", 32'(busy), 0);
    check("mid reset rd_en", 32'(bus.rd_en), 0);
    check("mid reset frame_done", 32'(frame_done), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    flush_to = src.size();
    repeat (2) @(posedge clk);
    run_vec(names[6], vecs[6]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
